// File: rtl/store_merge_unit.sv
// store_merge_unit: narrows SB/SH/SW stores into full-word writes, read-modify-write for sub-word lanes.
module store_merge_unit #(
  parameter int RD_LAT     = 1,
  parameter bit BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        misaligned
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;
  state_t      state, nxt;
  logic [31:0] addr_q, word_q, mask, ins, merged;
  logic [15:0] data_q;
  logic        half_q, accept, bad;
  logic [1:0]  cnt, lane;
  logic        hsel;
  assign accept = req_valid && req_ready;
  assign bad = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !accept ? IDLE : bad ? ERR : (req_size == 2'b10) ? WRITE : READ;
      READ:    nxt = WAIT;
      WAIT:    nxt = (cnt == 2'd0) ? WRITE : WAIT;
      WRITE:   nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  // Lane select: big-endian mirrors the byte index (3-k == ~k) and flips the half.
  assign lane   = addr_q[1:0] ^ {2{BIG_ENDIAN}};
  assign hsel   = addr_q[1] ^ BIG_ENDIAN;
  assign mask   = half_q ? (32'h0000_FFFF << {hsel, 4'd0}) : (32'h0000_00FF << {lane, 3'd0});
  assign ins    = half_q ? {2{data_q}} : {4{data_q[7:0]}};
  assign merged = (mem_rdata & ~mask) | (ins & mask);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      half_q <= 1'b0;
      word_q <= '0;
      cnt    <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
      data_q <= req_data[15:0];
      half_q <= req_size == 2'b01;
      word_q <= req_data;
    end else if (state == READ) begin
      cnt <= 2'(RD_LAT - 1);
    end else if (state == WAIT) begin
      if (cnt == 2'd0) word_q <= merged;
      else             cnt <= cnt - 2'd1;
    end
  assign req_ready  = (state == IDLE) && !rst;
  assign mem_re     = state == READ;
  assign mem_we     = state == WRITE;
  assign done       = state == WRITE;
  assign misaligned = state == ERR;
  assign mem_addr   = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata  = (state == WRITE) ? word_q : '0;
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed checks of an LE/RD_LAT=1 unit and a BE/RD_LAT=3 unit.
module tb_store_merge_unit;
  logic        clk = 0, rst = 1, vld_a = 0, vld_b = 0, sel = 0;
  logic [31:0] addr = 0, data = 0, mem_word = 0;
  logic [1:0]  size = 0;
  logic        rdy_a, re_a, we_a, done_a, mis_a, rdy_b, re_b, we_b, done_b, mis_b;
  logic [31:0] maddr_a, wd_a, rd_a, maddr_b, wd_b, rd_b;
  logic [3:0]  pipe_a = 0, pipe_b = 0;
  int          pass = 0, total = 0;
  always #5 clk = ~clk;
  // Memory model: read word is valid only exactly RD_LAT cycles after mem_re, garbage otherwise.
  always @(posedge clk) begin
    pipe_a <= {pipe_a[2:0], re_a};
    pipe_b <= {pipe_b[2:0], re_b};
  end
  assign rd_a = pipe_a[0] ? mem_word : 32'hA5A5_A5A5;
  assign rd_b = pipe_b[2] ? mem_word : 32'hA5A5_A5A5;
  store_merge_unit #(.RD_LAT(1), .BIG_ENDIAN(0)) dut_a (
    .clk(clk), .rst(rst), .req_valid(vld_a), .req_ready(rdy_a), .req_addr(addr), .req_data(data),
    .req_size(size), .mem_addr(maddr_a), .mem_re(re_a), .mem_rdata(rd_a), .mem_we(we_a),
    .mem_wdata(wd_a), .done(done_a), .misaligned(mis_a));
  store_merge_unit #(.RD_LAT(3), .BIG_ENDIAN(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vld_b), .req_ready(rdy_b), .req_addr(addr), .req_data(data),
    .req_size(size), .mem_addr(maddr_b), .mem_re(re_b), .mem_rdata(rd_b), .mem_we(we_b),
    .mem_wdata(wd_b), .done(done_b), .misaligned(mis_b));
  wire        o_rdy  = sel ? rdy_b : rdy_a;
  wire        o_re   = sel ? re_b : re_a;
  wire        o_we   = sel ? we_b : we_a;
  wire        o_done = sel ? done_b : done_a;
  wire        o_mis  = sel ? mis_b : mis_a;
  wire [31:0] o_addr = sel ? maddr_b : maddr_a;
  wire [31:0] o_wd   = sel ? wd_b : wd_a;
  // Issues one request (accept edge = cycle 0) and records first cycle of each pulse over 8 cycles.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] d, input logic [1:0] z,
                       output int c_re, output int c_we, output int c_done, output int c_mis,
                       output logic [31:0] re_addr, output logic [31:0] we_addr,
                       output logic [31:0] we_data, output int busy);
    c_re = 0; c_we = 0; c_done = 0; c_mis = 0; re_addr = 0; we_addr = 0; we_data = 0; busy = 0;
    @(negedge clk);
    sel = s; addr = a; data = d; size = z;
    if (s) vld_b = 1; else vld_a = 1;
    @(posedge clk); #1;
    vld_a = 0; vld_b = 0; addr = 32'hFFFF_FFFF; data = 32'h7777_7777; size = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (o_re && c_re == 0) begin c_re = c; re_addr = o_addr; end
      if (o_we && c_we == 0) begin c_we = c; we_addr = o_addr; we_data = o_wd; end
      if (o_done && c_done == 0) c_done = c;
      if (o_mis && c_mis == 0) c_mis = c;
      if (!o_rdy) busy++;
    end
  endtask
  task automatic test_reset;
    #12;
    total++; if (rdy_a !== 0 || re_a !== 0 || we_a !== 0) begin $display("FAIL reset_hold got rdy=%b re=%b we=%b want 0 0 0", rdy_a, re_a, we_a); end else pass++;
    @(negedge clk); rst = 0; #1;
    total++; if (rdy_a !== 1 || rdy_b !== 1) begin $display("FAIL reset_ready got %b %b want 1 1", rdy_a, rdy_b); end else pass++;
    total++; if ({re_a, we_a, done_a, mis_a, re_b, we_b, done_b, mis_b} !== 8'h00) begin $display("FAIL reset_strobes got %b want 0", {re_a, we_a, done_a, mis_a}); end else pass++;
    total++; if (maddr_a !== 0 || wd_a !== 0) begin $display("FAIL reset_buses got %h %h want 0 0", maddr_a, wd_a); end else pass++;
  endtask
  task automatic test_sub_le;
    int cr, cw, cd, cm, b; logic [31:0] ra, wa, wd;
    mem_word = 32'h1122_3344;
    issue(0, 32'h0000_0102, 32'hFFFF_FFAB, 2'b00, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (cr !== 1 || ra !== 32'h100) begin $display("FAIL sb_re got cyc=%0d addr=%h want 1 00000100", cr, ra); end else pass++;
    total++; if (cw !== 3 || cd !== 3) begin $display("FAIL sb_we_cycle got we=%0d done=%0d want 3 3", cw, cd); end else pass++;
    total++; if (wd !== 32'h11AB_3344 || wa !== 32'h100) begin $display("FAIL sb_wdata got %h@%h want 11ab3344@00000100", wd, wa); end else pass++;
    total++; if (b !== 3 || cm !== 0) begin $display("FAIL sb_busy got busy=%0d mis=%0d want 3 0", b, cm); end else pass++;
    issue(0, 32'h0000_0202, 32'h0000_BEEF, 2'b01, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (wd !== 32'hBEEF_3344 || wa !== 32'h200 || cw !== 3) begin $display("FAIL sh_hi got %h@%h cyc=%0d want beef3344@00000200 3", wd, wa, cw); end else pass++;
    issue(0, 32'h0000_0000, 32'h0000_BEEF, 2'b01, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (wd !== 32'h1122_BEEF || wa !== 32'h0) begin $display("FAIL sh_lo got %h@%h want 1122beef@00000000", wd, wa); end else pass++;
    issue(0, 32'h0000_0003, 32'h0000_0099, 2'b00, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (wd !== 32'h9922_3344) begin $display("FAIL sb_lane3 got %h want 99223344", wd); end else pass++;
  endtask
  task automatic test_word;
    int cr, cw, cd, cm, b; logic [31:0] ra, wa, wd;
    issue(0, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (cw !== 1 || cd !== 1 || cr !== 0) begin $display("FAIL sw_timing got we=%0d done=%0d re=%0d want 1 1 0", cw, cd, cr); end else pass++;
    total++; if (wd !== 32'hDEAD_BEEF || wa !== 32'h10) begin $display("FAIL sw_data got %h@%h want deadbeef@00000010", wd, wa); end else pass++;
  endtask
  task automatic test_back_to_back;
    logic w1, w2, r2, w3, w4; logic [31:0] d1, d3;
    @(negedge clk);
    sel = 0; addr = 32'h20; data = 32'h0102_0304; size = 2'b10; vld_a = 1;
    @(posedge clk); #1;
    addr = 32'h24; data = 32'hA0B0_C0D0;
    w1 = we_a; d1 = wd_a;
    @(posedge clk); #1; w2 = we_a; r2 = rdy_a;
    @(posedge clk); #1; w3 = we_a; d3 = wd_a; vld_a = 0;
    @(posedge clk); #1; w4 = we_a;
    total++; if (w1 !== 1 || d1 !== 32'h0102_0304) begin $display("FAIL b2b_first got we=%b %h want 1 01020304", w1, d1); end else pass++;
    total++; if (w2 !== 0 || r2 !== 1) begin $display("FAIL b2b_gap got we=%b rdy=%b want 0 1", w2, r2); end else pass++;
    total++; if (w3 !== 1 || d3 !== 32'hA0B0_C0D0 || w4 !== 0) begin $display("FAIL b2b_second got we=%b %h next=%b want 1 a0b0c0d0 0", w3, d3, w4); end else pass++;
  endtask
  task automatic test_misaligned;
    int cr, cw, cd, cm, b; logic [31:0] ra, wa, wd;
    logic [31:0] av [3] = '{32'h1, 32'h6, 32'h0};
    logic [1:0]  zv [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      issue(0, av[i], 32'h1234_5678, zv[i], cr, cw, cd, cm, ra, wa, wd, b);
      total++; if (cm !== 1 || cr !== 0 || cw !== 0 || cd !== 0) begin $display("FAIL misaligned_%0d got mis=%0d re=%0d we=%0d done=%0d want 1 0 0 0", i, cm, cr, cw, cd); end else pass++;
    end
  endtask
  task automatic test_big_endian;
    int cr, cw, cd, cm, b; logic [31:0] ra, wa, wd;
    mem_word = 32'h1122_3344;
    issue(1, 32'h0000_0000, 32'h0000_005A, 2'b00, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (cr !== 1 || cw !== 5 || cd !== 5) begin $display("FAIL be_sb_timing got re=%0d we=%0d done=%0d want 1 5 5", cr, cw, cd); end else pass++;
    total++; if (wd !== 32'h5A22_3344) begin $display("FAIL be_sb_data got %h want 5a223344", wd); end else pass++;
    issue(1, 32'h0000_0002, 32'h0000_CAFE, 2'b01, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (wd !== 32'h1122_CAFE) begin $display("FAIL be_sh_data got %h want 1122cafe", wd); end else pass++;
  endtask
  task automatic test_reset_midop;
    int wes = 0, nrdy = 0;
    int cr, cw, cd, cm, b; logic [31:0] ra, wa, wd;
    @(negedge clk);
    sel = 1; addr = 32'h40; data = 32'h33; size = 2'b00; vld_b = 1;
    @(posedge clk); #1; vld_b = 0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (re_b !== 0 || we_b !== 0 || rdy_b !== 0) begin $display("FAIL midop_pre got re=%b we=%b rdy=%b want 0 0 0", re_b, we_b, rdy_b); end else pass++;
    rst = 1; #1;
    total++; if ({re_b, we_b, done_b, mis_b} !== 4'h0 || maddr_b !== 0 || wd_b !== 0) begin $display("FAIL midop_reset got strobes=%b addr=%h wd=%h want 0", {re_b, we_b, done_b, mis_b}, maddr_b, wd_b); end else pass++;
    @(negedge clk); rst = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (we_b) wes++;
      if (!rdy_b) nrdy++;
    end
    total++; if (wes !== 0 || nrdy !== 0) begin $display("FAIL midop_after got we=%0d notready=%0d want 0 0", wes, nrdy); end else pass++;
    issue(1, 32'h0000_0044, 32'h0BAD_F00D, 2'b10, cr, cw, cd, cm, ra, wa, wd, b);
    total++; if (cw !== 1 || wd !== 32'h0BAD_F00D || wa !== 32'h44) begin $display("FAIL midop_sw got cyc=%0d %h@%h want 1 0badf00d@00000044", cw, wd, wa); end else pass++;
  endtask
  initial begin
    test_reset;
    test_sub_le;
    test_word;
    test_back_to_back;
    test_misaligned;
    test_big_endian;
    test_reset_midop;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
